// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//
// Receive-side partner of serial_transmitter. Deserialises the single-wire
// frame seen on rx (start bit 0, 8 data bits LSB first, optional even-parity
// bit, stop bit 1) and holds the received byte plus error flags until the
// consumer acknowledges it with read.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   PARITY_EN     1 = frame carries an even-parity bit after the data
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   rx             serial line, idle high
//   read           consumer acknowledge, clears data_ready (and overrun)
//   data_received  last committed byte
//   data_ready     a byte is held and has not been read yet
//   parity_err     parity mismatch on the held byte
//   frame_err      stop bit sampled low on the held byte
//   overrun        sticky: a byte was committed over an unread one
//   busy           receiver is inside a frame (any state except IDLE)
// -----------------------------------------------------------------------------
module serial_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data_received,
    output logic       data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam bit HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic          sync1_reg;
    logic          rx_s;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          p_reg;

    logic          bit_end;
    logic          cnt_clear;
    logic          shift_en;
    logic          parity_sample;
    logic          commit;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle line level so that reset
    // release never looks like a start bit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rx_s      <= sync1_reg;
        end
    end

    assign bit_end = (cnt_reg == CNT_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. The start bit is re-checked half a bit after the
    // falling edge; every later sample happens a full bit period after the
    // previous one, so all samples land mid-bit.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx_reg == 3'd7)) begin
                    state_next = HAS_PARITY ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / strobe logic
    // -------------------------------------------------------------------------
    always_comb begin
        busy          = (state_reg != IDLE);
        shift_en      = (state_reg == DATA)   && bit_end;
        parity_sample = (state_reg == PARITY) && bit_end;
        commit        = (state_reg == STOP)   && bit_end;
        // The bit counter restarts on every sample point and whenever the
        // state changes (covers START->DATA and the glitch return to IDLE).
        cnt_clear     = (state_reg == IDLE) || bit_end || (state_next != state_reg);
    end

    // -------------------------------------------------------------------------
    // Frame datapath: bit counter, bit index, shift register, parity check
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            p_reg       <= 1'b0;
        end else begin
            cnt_reg <= cnt_clear ? '0 : cnt_reg + 1'b1;

            if (state_reg == START) begin
                bit_idx_reg <= '0;
            end else if (shift_en) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end

            // LSB arrives first, so shift right and insert at the top.
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end

            // Even parity: received parity bit XOR data reduction is 0 when
            // the frame is good.
            if (parity_sample) begin
                p_reg <= rx_s ^ (^shift_reg);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Holding register and consumer handshake. A commit takes priority over a
    // simultaneous read; the read still prevents overrun for that commit since
    // the previous byte was consumed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_received <= '0;
            data_ready    <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else if (commit) begin
            data_received <= shift_reg;
            data_ready    <= 1'b1;
            parity_err    <= HAS_PARITY & p_reg;
            frame_err     <= ~rx_s;
            overrun       <= overrun | (data_ready & ~read);
        end else if (read && data_ready) begin
            data_ready    <= 1'b0;
            overrun       <= 1'b0;
        end
    end

endmodule
